// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/memory status into the controller,
// stage enables, flushes and status back out to the datapath.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic [1:0]       mem_M;
    logic             dmem_ready;
    logic             branch_taken;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             dmem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       state;

    modport master (
        output id_rs, id_rt, ex_memread, ex_rt, mem_M, dmem_ready, branch_taken,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               dmem_req, mem_err, stall_cnt, state
    );

    modport slave (
        input  id_rs, id_rt, ex_memread, ex_rt, mem_M, dmem_ready, branch_taken,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               dmem_req, mem_err, stall_cnt, state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: memory-wait stall, branch flush and
// load-use bubble, with a memory timeout that halts until reset.
module pipe_ctrl #(
    parameter int CNT_W  = 16,
    parameter int MEM_TO = 255
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0]       TO8   = 8'(MEM_TO);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_wait, w_wait_nxt, w_wait_inc;
    logic             r_err, w_err_nxt;
    logic [CNT_W-1:0] r_stall;

    logic w_lu, w_mem_act;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
    logic w_ifid_flush, w_idex_flush, w_dmem_req;

    always_comb begin
        w_lu = bus.ex_memread && (bus.ex_rt != 5'd0) &&
               ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        w_mem_act  = (bus.mem_M != 2'b00);
        w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait;
        w_err_nxt    = r_err;
        w_pc_en      = 1'b1;
        w_ifid_en    = 1'b1;
        w_idex_en    = 1'b1;
        w_exmem_en   = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_dmem_req   = 1'b0;

        case (r_state)
            RUN, MEM_WAIT: begin
                w_dmem_req = (r_state == MEM_WAIT) || w_mem_act;
                if ((r_state == RUN && w_mem_act && !bus.dmem_ready) ||
                    (r_state == MEM_WAIT && !bus.dmem_ready)) begin
                    // Memory stall freezes every stage, overriding branch and load-use.
                    w_pc_en    = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                    if (r_state == RUN) begin
                        w_state_nxt = MEM_WAIT;
                        w_wait_nxt  = 8'd1;
                    end else begin
                        w_wait_nxt = w_wait_inc;
                        if (w_wait_inc >= TO8) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = HALT;
                        end
                    end
                end else begin
                    if (bus.branch_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_lu) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                    w_state_nxt = RUN;
                    w_wait_nxt  = 8'd0;
                end
            end
            HALT: begin
                w_pc_en    = 1'b0;
                w_ifid_en  = 1'b0;
                w_idex_en  = 1'b0;
                w_exmem_en = 1'b0;
            end
            default: begin
                w_pc_en     = 1'b0;
                w_ifid_en   = 1'b0;
                w_idex_en   = 1'b0;
                w_exmem_en  = 1'b0;
                w_state_nxt = RUN;
                w_wait_nxt  = 8'd0;
            end
        endcase

        if (rst) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_exmem_en   = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_dmem_req   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_wait  <= '0;
            r_err   <= 1'b0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_err   <= w_err_nxt;
            if (!w_pc_en && (r_stall != '1))
                r_stall <= r_stall + C_ONE;
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.ifid_en    = w_ifid_en;
    assign bus.idex_en    = w_idex_en;
    assign bus.exmem_en   = w_exmem_en;
    assign bus.ifid_flush = w_ifid_flush;
    assign bus.idex_flush = w_idex_flush;
    assign bus.dmem_req   = w_dmem_req;
    assign bus.mem_err    = r_err;
    assign bus.stall_cnt  = r_stall;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Drives two pipe_ctrl instances (default and small parameters) with
// directed and random stimulus, checked against a rule-level model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_ctrl_if #(.CNT_W(4))  bus_b ();

    pipe_ctrl #(.CNT_W(16), .MEM_TO(255)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    pipe_ctrl #(.CNT_W(4),  .MEM_TO(4))   dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int compared   = 0;
    int mismatched = 0;

    logic [4:0] s_rs, s_rt, s_ert;
    logic       s_mrd, s_rdy, s_br;
    logic [1:0] s_mm;

    // Model state per instance: 0 running, 1 waiting on memory, 2 halted.
    int m_st[2];
    int m_wait[2];
    int m_stall[2];
    int m_err[2];
    int m_to[2]   = '{255, 4};
    int m_smax[2] = '{65535, 15};

    logic [6:0] last_comb_a;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Expected {pc,ifid,idex,exmem,ifid_flush,idex_flush,dmem_req} from the priority list.
    function automatic logic [6:0] expect_comb(input int st);
        bit lu, req;
        lu = s_mrd && (s_ert != 0) && ((s_ert == s_rs) || (s_ert == s_rt));
        if (rst) return 7'b0000110;
        if (st == 2) return 7'b0000000;
        req = (st == 1) || (s_mm != 0);
        if (!s_rdy && (st == 1 || s_mm != 0)) return {6'b000000, req};
        if (s_br) return {6'b111111, req};
        if (lu)   return {6'b001101, req};
        return {6'b111100, req};
    endfunction

    task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic mrd, input logic [4:0] ert, input logic [1:0] mm,
                        input logic rdy, input logic br);
        logic [6:0] e[2];
        rst = r; s_rs = rs; s_rt = rt; s_mrd = mrd; s_ert = ert; s_mm = mm; s_rdy = rdy; s_br = br;
        bus_a.id_rs = rs; bus_a.id_rt = rt; bus_a.ex_memread = mrd; bus_a.ex_rt = ert;
        bus_a.mem_M = mm; bus_a.dmem_ready = rdy; bus_a.branch_taken = br;
        bus_b.id_rs = rs; bus_b.id_rt = rt; bus_b.ex_memread = mrd; bus_b.ex_rt = ert;
        bus_b.mem_M = mm; bus_b.dmem_ready = rdy; bus_b.branch_taken = br;
        #1;
        for (int i = 0; i < 2; i++) e[i] = expect_comb(m_st[i]);
        last_comb_a = {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
                       bus_a.ifid_flush, bus_a.idex_flush, bus_a.dmem_req};
        chk("comb",  0, 32'(last_comb_a), 32'(e[0]));
        chk("state", 0, 32'(bus_a.state), 32'(m_st[0]));
        chk("stall", 0, 32'(bus_a.stall_cnt), 32'(m_stall[0]));
        chk("err",   0, 32'(bus_a.mem_err), 32'(m_err[0]));
        chk("comb",  1, 32'({bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
                             bus_b.ifid_flush, bus_b.idex_flush, bus_b.dmem_req}), 32'(e[1]));
        chk("state", 1, 32'(bus_b.state), 32'(m_st[1]));
        chk("stall", 1, 32'(bus_b.stall_cnt), 32'(m_stall[1]));
        chk("err",   1, 32'(bus_b.mem_err), 32'(m_err[1]));
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_st[i] = 0; m_wait[i] = 0; m_stall[i] = 0; m_err[i] = 0;
            end else begin
                if (!e[i][6] && m_stall[i] < m_smax[i]) m_stall[i]++;
                if (m_st[i] == 0 && mm != 0 && !rdy) begin
                    m_st[i] = 1; m_wait[i] = 1;
                end else if (m_st[i] == 1) begin
                    if (rdy) begin
                        m_st[i] = 0; m_wait[i] = 0;
                    end else begin
                        m_wait[i]++;
                        if (m_wait[i] >= m_to[i]) begin
                            m_err[i] = 1; m_st[i] = 2;
                        end
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        s_rs = '0; s_rt = '0; s_mrd = 1'b0; s_ert = '0; s_mm = '0; s_rdy = 1'b0; s_br = 1'b0;
        bus_a.id_rs = '0; bus_a.id_rt = '0; bus_a.ex_memread = 1'b0; bus_a.ex_rt = '0;
        bus_a.mem_M = '0; bus_a.dmem_ready = 1'b0; bus_a.branch_taken = 1'b0;
        bus_b.id_rs = '0; bus_b.id_rt = '0; bus_b.ex_memread = 1'b0; bus_b.ex_rt = '0;
        bus_b.mem_M = '0; bus_b.dmem_ready = 1'b0; bus_b.branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_wait[i] = 0; m_stall[i] = 0; m_err[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);

        do_reset();
        chk("rst_comb", 0, 32'(last_comb_a), 32'h06);
        idle();

        // Load-use bubble on rs match
        step(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 2'b00, 1'b1, 1'b0);
        chk("lu_comb", 0, 32'(last_comb_a), 32'h1A);
        idle();
        chk("lu_stall", 0, 32'(bus_a.stall_cnt), 32'd1);

        // Load into r0 never stalls
        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 2'b00, 1'b1, 1'b0);
        chk("r0_comb", 0, 32'(last_comb_a), 32'h78);

        // Three-cycle memory wait
        do_reset();
        repeat (3) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b0, 1'b0);
        chk("mw_comb", 0, 32'(last_comb_a), 32'h01);
        chk("mw_state", 0, 32'(bus_a.state), 32'd1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'b10, 1'b1, 1'b0);
        chk("mw_ready", 0, 32'(last_comb_a), 32'h79);
        idle();
        chk("mw_stall", 0, 32'(bus_a.stall_cnt), 32'd3);

        // Branch wins over load-use
        step(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 2'b00, 1'b1, 1'b1);
        chk("br_comb", 0, 32'(last_comb_a), 32'h7E);
        idle();
        chk("br_stall", 0, 32'(bus_a.stall_cnt), 32'd3);

        // Timeout to HALT on the small instance
        do_reset();
        repeat (6) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'b01, 1'b0, 1'b0);
        chk("to_state", 1, 32'(bus_b.state), 32'd2);
        chk("to_err", 1, 32'(bus_b.mem_err), 32'd1);
        chk("to_en", 1, 32'({bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en}), 32'd0);
        do_reset();
        chk("to_rst_state", 1, 32'(bus_b.state), 32'd0);
        chk("to_rst_err", 1, 32'(bus_b.mem_err), 32'd0);
        chk("to_rst_stall", 1, 32'(bus_b.stall_cnt), 32'd0);
        chk("to_rst_req", 1, 32'(bus_b.dmem_req), 32'd0);
        idle();

        // Saturation of the 4-bit stall counter
        do_reset();
        repeat (20) step(1'b0, 5'd7, 5'd0, 1'b1, 5'd7, 2'b00, 1'b1, 1'b0);
        chk("sat_b", 1, 32'(bus_b.stall_cnt), 32'd15);
        chk("sat_a", 0, 32'(bus_a.stall_cnt), 32'd20);

        // Random traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) < 3),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00,
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
